cpu_controller: RTL and testbench

- Multi-cycle control sequencer for the 8-bit RISC CPU.
- Drives the per-phase control strobes for PC, IR, accumulator and memory.
- Decodes the 3-bit opcode that the instruction register presents to the ALU, and consumes the ALU's is_zero flag to resolve SKZ.
- Implements the 8-phase fetch/execute cycle, plus a sticky HALTED state and a memory-ready stall.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/cpu_controller.sv | 150 +++++++++++++++
 tb/tb_cpu_controller.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Opcode and phase encodings shared by the CPU controller and ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    // Instructions that read an operand from memory and write the accumulator.
    function automatic logic is_aluop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_controller.sv
// ============================================================================
// Module      : cpu_controller
// Description : 8-phase fetch/execute sequencer with memory stall and sticky
//               halt. Macro CPU_CTRL_RETIRE_CNT_EN adds a retired-instruction
//               counter output (instr_count).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_controller
    import cpu_pkg::*;
#(
    parameter int OPCODE_WIDTH = 3,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero,
    input  logic                    mem_ready,
    output logic                    sel,
    output logic                    rd,
    output logic                    ld_ir,
    output logic                    inc_pc,
    output logic                    ld_pc,
    output logic                    ld_ac,
    output logic                    data_e,
    output logic                    wr,
    output logic                    halt
`ifdef CPU_CTRL_RETIRE_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]    instr_count
`endif
);

    generate
        if (OPCODE_WIDTH != 3) begin : g_opcode_width_check
            $error("cpu_controller: OPCODE_WIDTH must be 3");
        end
        if (CNT_WIDTH < 1) begin : g_cnt_width_check
            $error("cpu_controller: CNT_WIDTH must be at least 1");
        end
    endgenerate

    phase_t r_phase;
    logic   r_halted;

    logic w_aluop;
    logic w_skz;
    logic w_sto;
    logic w_jmp;
    logic w_hlt;
    logic w_stall;

    assign w_aluop = is_aluop(opcode);
    assign w_skz   = (opcode == OP_SKZ);
    assign w_sto   = (opcode == OP_STO);
    assign w_jmp   = (opcode == OP_JMP);
    assign w_hlt   = (opcode == OP_HLT);

    // Only phases that actually read memory wait for it.
    assign w_stall = !mem_ready &&
                     ((r_phase == PH_INST_FETCH) || ((r_phase == PH_OP_FETCH) && w_aluop));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase  <= PH_INST_ADDR;
            r_halted <= 1'b0;
        end else if (!r_halted) begin
            if ((r_phase == PH_OP_ADDR) && w_hlt) begin
                r_phase  <= PH_INST_ADDR;
                r_halted <= 1'b1;
            end else if (!w_stall) begin
                r_phase <= phase_t'(r_phase + 3'd1);
            end
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        data_e = 1'b0;
        wr     = 1'b0;
        halt   = 1'b0;
        if (r_halted) begin
            halt = 1'b1;
        end else begin
            case (r_phase)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = w_hlt;
                end
                PH_OP_FETCH: begin
                    rd = w_aluop;
                end
                PH_ALU_OP: begin
                    rd     = w_aluop;
                    inc_pc = w_skz & zero;
                    ld_pc  = w_jmp;
                    data_e = w_sto;
                end
                PH_STORE: begin
                    rd     = w_aluop;
                    inc_pc = w_jmp;
                    ld_pc  = w_jmp;
                    ld_ac  = w_aluop;
                    wr     = w_sto;
                    data_e = w_sto;
                end
                default: ;
            endcase
        end
    end

`ifdef CPU_CTRL_RETIRE_CNT_EN
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = 1;

    logic [CNT_WIDTH-1:0] r_instr_count;

    // STORE never stalls, so being in STORE while running means leaving it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_count <= '0;
        end else if (!r_halted && (r_phase == PH_STORE) && (r_instr_count != '1)) begin
            r_instr_count <= r_instr_count + c_cnt_one;
        end
    end

    assign instr_count = r_instr_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu_controller.sv
// ============================================================================
// Module      : tb_cpu_controller
// Description : Scoreboard bench for cpu_controller using directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_controller;

    localparam int TB_CNT_WIDTH = 4;

    // Expected strobe vectors {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,data_e,wr,halt}
    localparam logic [8:0] E_PH0   = 9'b100000000;
    localparam logic [8:0] E_PH1   = 9'b110000000;
    localparam logic [8:0] E_PH23  = 9'b111000000;
    localparam logic [8:0] E_PH4   = 9'b000100000;
    localparam logic [8:0] E_NONE  = 9'b000000000;
    localparam logic [8:0] E_RD    = 9'b010000000;
    localparam logic [8:0] E_RDLA  = 9'b010001000;
    localparam logic [8:0] E_INC   = 9'b000100000;
    localparam logic [8:0] E_STO6  = 9'b000000100;
    localparam logic [8:0] E_STO7  = 9'b000000110;
    localparam logic [8:0] E_JMP6  = 9'b000010000;
    localparam logic [8:0] E_JMP7  = 9'b000110000;
    localparam logic [8:0] E_HLT4  = 9'b000100001;
    localparam logic [8:0] E_HALTD = 9'b000000001;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt;
    logic [8:0] outs;
`ifdef CPU_CTRL_RETIRE_CNT_EN
    logic [TB_CNT_WIDTH-1:0] instr_count;
    logic [TB_CNT_WIDTH-1:0] cnt_q[$];
`endif

    logic [8:0] exp_q[$];
    string      name_q[$];
    int         checks = 0;
    int         errors = 0;

    assign outs = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt};

    always #5 clk = ~clk;

    cpu_controller #(
        .OPCODE_WIDTH(3),
        .CNT_WIDTH   (TB_CNT_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .zero     (zero),
        .mem_ready(mem_ready),
        .sel      (sel),
        .rd       (rd),
        .ld_ir    (ld_ir),
        .inc_pc   (inc_pc),
        .ld_pc    (ld_pc),
        .ld_ac    (ld_ac),
        .data_e   (data_e),
        .wr       (wr),
        .halt     (halt)
`ifdef CPU_CTRL_RETIRE_CNT_EN
        ,
        .instr_count(instr_count)
`endif
    );

    // Monitor: compares whatever the stimulus queued for this cycle.
    always @(negedge clk) begin
        logic [8:0] e;
        string      n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (outs !== e) begin
                errors++;
                $display("FAIL %s: strobes got %b expected %b", n, outs, e);
            end
        end
`ifdef CPU_CTRL_RETIRE_CNT_EN
        if (cnt_q.size() > 0) begin
            logic [TB_CNT_WIDTH-1:0] c;
            c = cnt_q.pop_front();
            checks++;
            if (instr_count !== c) begin
                errors++;
                $display("FAIL instr_count: got %0d expected %0d", instr_count, c);
            end
        end
`endif
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Queue one expected vector for the current cycle, then advance a clock.
    task automatic chk(input logic [8:0] v, input string n);
        exp_q.push_back(v);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [2:0] op, input logic z,
                             input logic [8:0] e5, input logic [8:0] e6,
                             input logic [8:0] e7, input string n);
        opcode = op;
        zero   = z;
        chk(E_PH0, {n, "_ph0"});
        chk(E_PH1, {n, "_ph1"});
        chk(E_PH23, {n, "_ph2"});
        chk(E_PH23, {n, "_ph3"});
        chk(E_PH4, {n, "_ph4"});
        chk(e5, {n, "_ph5"});
        chk(e6, {n, "_ph6"});
        chk(e7, {n, "_ph7"});
    endtask

    // mem_ready low for 3 clocks on entry to INST_FETCH and OP_FETCH.
    task automatic run_stall(input logic [2:0] op, input logic of_holds,
                             input logic [8:0] e5, input logic [8:0] e6,
                             input logic [8:0] e7, input string n);
        opcode = op;
        zero   = 1'b0;
        chk(E_PH0, {n, "_ph0"});
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) chk(E_PH1, {n, "_if_hold"});
        mem_ready = 1'b1;
        chk(E_PH1, {n, "_ph1"});
        chk(E_PH23, {n, "_ph2"});
        chk(E_PH23, {n, "_ph3"});
        chk(E_PH4, {n, "_ph4"});
        mem_ready = 1'b0;
        if (of_holds) begin
            for (int i = 0; i < 3; i++) chk(e5, {n, "_of_hold"});
            mem_ready = 1'b1;
        end
        chk(e5, {n, "_ph5"});
        mem_ready = 1'b1;
        chk(e6, {n, "_ph6"});
        chk(e7, {n, "_ph7"});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 3'b000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef CPU_CTRL_RETIRE_CNT_EN
        cnt_q.push_back('0);
`endif
        run_instr(3'b010, 1'b0, E_RD, E_RD, E_RDLA, "add");
        run_instr(3'b010, 1'b1, E_RD, E_RD, E_RDLA, "add_zero_ignored");
        run_instr(3'b001, 1'b1, E_NONE, E_INC, E_NONE, "skz_z1");
        run_instr(3'b001, 1'b0, E_NONE, E_NONE, E_NONE, "skz_z0");
        run_instr(3'b110, 1'b0, E_NONE, E_STO6, E_STO7, "sto");
        run_instr(3'b111, 1'b0, E_NONE, E_JMP6, E_JMP7, "jmp");
        run_instr(3'b011, 1'b0, E_RD, E_RD, E_RDLA, "and");

        run_stall(3'b101, 1'b1, E_RD, E_RD, E_RDLA, "lda_stall");
        run_stall(3'b110, 1'b0, E_NONE, E_STO6, E_STO7, "sto_nostall");

        // HLT, then inputs wiggled while halted.
        opcode = 3'b000;
        chk(E_PH0, "hlt_ph0");
        chk(E_PH1, "hlt_ph1");
        chk(E_PH23, "hlt_ph2");
        chk(E_PH23, "hlt_ph3");
        mem_ready = 1'b0;
        chk(E_HLT4, "hlt_ph4");
        for (int i = 0; i < 22; i++) begin
            opcode    = 3'($urandom_range(0, 7));
            zero      = 1'($urandom_range(0, 1));
            mem_ready = 1'($urandom_range(0, 1));
            chk(E_HALTD, "halted");
        end
        mem_ready = 1'b1;
        do_reset();
        chk(E_PH0, "post_halt_reset");
        chk(E_PH1, "post_halt_ph1");
        opcode = 3'b010;
        chk(E_PH23, "post_halt_ph2");
        chk(E_PH23, "post_halt_ph3");
        chk(E_PH4, "post_halt_ph4");
        chk(E_RD, "post_halt_ph5");
        chk(E_RD, "post_halt_ph6");
        chk(E_RDLA, "post_halt_ph7");

        // Reset during ALU_OP of a JMP.
        opcode = 3'b111;
        chk(E_PH0, "jmp_rst_ph0");
        chk(E_PH1, "jmp_rst_ph1");
        chk(E_PH23, "jmp_rst_ph2");
        chk(E_PH23, "jmp_rst_ph3");
        chk(E_PH4, "jmp_rst_ph4");
        chk(E_NONE, "jmp_rst_ph5");
        rst = 1'b1;
        chk(E_JMP6, "jmp_rst_ph6");
        rst = 1'b0;
        chk(E_PH0, "jmp_rst_after");
        chk(E_PH1, "jmp_rst_after_ph1");

        // Reset coinciding with HLT in OP_ADDR: reset wins, no halt.
        opcode = 3'b000;
        chk(E_PH23, "hlt_rst_ph2");
        chk(E_PH23, "hlt_rst_ph3");
        rst = 1'b1;
        chk(E_HLT4, "hlt_rst_ph4");
        rst = 1'b0;
        chk(E_PH0, "hlt_rst_after");
        chk(E_PH1, "hlt_rst_not_halted");

`ifdef CPU_CTRL_RETIRE_CNT_EN
        do_reset();
        for (int i = 0; i < 5; i++) run_instr(3'b010, 1'b0, E_RD, E_RD, E_RDLA, "cnt_add");
        opcode = 3'b000;
        chk(E_PH0, "cnt_hlt_ph0");
        chk(E_PH1, "cnt_hlt_ph1");
        chk(E_PH23, "cnt_hlt_ph2");
        chk(E_PH23, "cnt_hlt_ph3");
        chk(E_HLT4, "cnt_hlt_ph4");
        cnt_q.push_back(TB_CNT_WIDTH'(5));
        chk(E_HALTD, "cnt_halted");
        chk(E_HALTD, "cnt_halted2");
        do_reset();
        cnt_q.push_back('0);
        for (int i = 0; i < 16; i++) run_instr(3'b010, 1'b0, E_RD, E_RD, E_RDLA, "sat_add");
        cnt_q.push_back('1);
        chk(E_PH0, "sat_ph0");
`endif

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
